// File: rtl/risc_mem_pkg.sv
// Shared constants for the RISC memory responder: I/O page offsets and FF01 bit layout.
package risc_mem_pkg;

    localparam logic [15:0] IO_TXDATA = 16'd0;
    localparam logic [15:0] IO_TXSTAT = 16'd1;
    localparam logic [15:0] IO_STATUS = 16'd2;
    localparam logic [15:0] IO_TIMER  = 16'd3;

    localparam int OVF_B     = 7;
    localparam int FULL_B    = 6;
    localparam int EMPTY_B   = 5;
    localparam int OVF_CLR_B = 7;

    function automatic logic [15:0] tx_stat_word(input logic ovf, input logic full,
                                                 input logic empty, input logic [4:0] cnt);
        logic [15:0] w;
        w          = '0;
        w[4:0]     = cnt;
        w[EMPTY_B] = empty;
        w[FULL_B]  = full;
        w[OVF_B]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/risc_tx_fifo.sv
// Transmit FIFO for the I/O page. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; head reads 0 while empty.
module risc_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/risc_mem_responder.sv
// Zero-wait-state memory responder for the 16-bit RISC core: word RAM plus an I/O page
// (tx FIFO, overflow flag, status snapshot). Optional timer at FF03 under RISC_MEM_TIMER_EN.
module risc_mem_responder
    import risc_mem_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Address,
    input  logic [15:0] D_Out,
    input  logic        mw_en,
    input  logic [7:0]  status,
    output logic [15:0] D_in,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]       ram [2**ADDR_W];
    logic              is_io;
    logic [15:0]       io_off;
    logic              wr_ram;
    logic              wr_txdata;
    logic              wr_txstat;
    logic              fifo_pop;
    logic [15:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [4:0]        cnt5;
    logic              ovf;
    logic [7:0]        stat_q;
    logic [15:0]       timer_val;

    assign is_io     = (Address >= IO_BASE);
    assign io_off    = Address - IO_BASE;
    assign wr_ram    = mw_en && !is_io;
    assign wr_txdata = mw_en && is_io && (io_off == IO_TXDATA);
    assign wr_txstat = mw_en && is_io && (io_off == IO_TXSTAT);
    assign cnt5      = 5'(fifo_count);

    // Egress handshake: a word transfers on any rising edge where tx_valid && tx_ready;
    // while tx_valid is high and no transfer occurs, tx_data holds its value.
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;
    assign fifo_pop = tx_valid && tx_ready;

    risc_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (D_Out),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // RAM keeps its contents across reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_ram && reset) begin
            ram[Address[ADDR_W-1:0]] <= D_Out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf    <= 1'b0;
            stat_q <= '0;
        end else begin
            stat_q <= status;
            if (wr_txdata && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end else if (wr_txstat && D_Out[OVF_CLR_B]) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef RISC_MEM_TIMER_EN
    logic        wr_timer;
    logic [15:0] timer_q;

    assign wr_timer  = mw_en && is_io && (io_off == IO_TIMER);
    assign timer_val = timer_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (wr_timer) begin
            timer_q <= D_Out;
        end else begin
            timer_q <= timer_q + 16'd1;
        end
    end
`else
    assign timer_val = '0;
`endif

    always_comb begin
        D_in = '0;
        if (!is_io) begin
            D_in = ram[Address[ADDR_W-1:0]];
        end else begin
            case (io_off)
                IO_TXDATA: D_in = fifo_head;
                IO_TXSTAT: D_in = tx_stat_word(ovf, fifo_full, fifo_empty, cnt5);
                IO_STATUS: D_in = {8'h00, stat_q};
                IO_TIMER:  D_in = timer_val;
                default:   D_in = '0;
            endcase
        end
    end

endmodule
